// File: rtl/uart_pkg.sv
// Shared constants for the buffered UART: register offsets, STATUS/CTRL bit
// positions and the TX/RX state encodings.
package uart_pkg;

  localparam logic [2:0] REG_TXDATA = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_RXDATA = 3'd2;
  localparam logic [2:0] REG_DIV    = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;

  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_RX_EMPTY     = 2;
  localparam int ST_RX_FULL      = 3;
  localparam int ST_RX_OVERRUN   = 4;
  localparam int ST_FRAME_ERR    = 5;
  localparam int ST_TX_DROP      = 6;
  localparam int ST_PARITY_ERR   = 7;
  localparam int ST_RX_LEVEL_LSB = 16;

  localparam int CTRL_RX_IRQ_EN  = 0;
  localparam int CTRL_TXE_IRQ_EN = 1;
  localparam int CTRL_ERR_IRQ_EN = 2;
  localparam int CTRL_LOOPBACK   = 3;

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;

  localparam logic [3:0] LAST_TICK = 4'd15;
  localparam logic [3:0] MID_TICK  = 4'd7;

endpackage

// File: rtl/uart_fifo_sync.sv
// Synchronous FIFO with a combinational head output; a pop frees a slot for a
// push in the same cycle, so a full FIFO still accepts push+pop together.
module uart_fifo_sync #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_fifo.sv
// Buffered UART for the PicoSoC IO bus: programmable 16x baud divisor, TX/RX
// FIFOs, sticky error status and a level irq. Define UART_PARITY_EN to add a parity bit.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_RESET  = 325,
  parameter int PARITY_ODD = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  input  logic        wstrb,
  output logic [31:0] rdata,
  input  logic        rxd,
  output logic        txd,
  output logic        irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                 valid_q, access, wr_acc, rd_acc;
  logic [15:0]          div, baud_cnt;
  logic                 tick;
  logic [3:0]           ctrl;
  logic [3:0]           sticky, sticky_set;
  logic [31:0]          status;
  logic                 unused_bits;

  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_BITS-1:0] tx_dout;
  logic [LW-1:0]        tx_level;
  logic                 rx_pop, rx_full, rx_empty, rx_done;
  logic [DATA_BITS-1:0] rx_dout;
  logic [LW-1:0]        rx_level;

  logic [2:0]           tx_state, rx_state;
  logic [3:0]           tx_tick, rx_tick;
  logic [2:0]           tx_bit, rx_bit;
  logic [DATA_BITS-1:0] tx_shift, rx_shift, hold_data;
  logic                 hold_valid, tx_line, tx_bit_done, tx_launch, tx_idle;
  logic [1:0]           rx_sync;
  logic                 rx_line, rx_prev, rx_sample, par_err_set;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  assign access = valid && !valid_q;
  assign wr_acc = access && wstrb;
  assign rd_acc = access && !wstrb;
  assign unused_bits = ^{wdata[31:16], tx_level, 1'(PARITY_ODD)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div  <= 16'(DIV_RESET);
      ctrl <= '0;
    end else if (wr_acc) begin
      if (addr == REG_DIV)  div  <= wdata[15:0];
      if (addr == REG_CTRL) ctrl <= wdata[3:0];
    end
  end

  // Writing DIV restarts the count so the new rate takes effect from a clean phase.
  assign tick = (baud_cnt == div);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         baud_cnt <= '0;
    else if (wr_acc && addr == REG_DIV) baud_cnt <= '0;
    else if (tick)                     baud_cnt <= '0;
    else                               baud_cnt <= baud_cnt + 16'd1;
  end

  assign tx_push = wr_acc && (addr == REG_TXDATA);
  assign rx_pop  = rd_acc && (addr == REG_RXDATA) && !rx_empty;

  uart_fifo_sync #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop),
    .din(wdata[DATA_BITS-1:0]), .dout(tx_dout), .full(tx_full),
    .empty(tx_empty), .level(tx_level)
  );

  uart_fifo_sync #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_done), .pop(rx_pop),
    .din(rx_shift), .dout(rx_dout), .full(rx_full),
    .empty(rx_empty), .level(rx_level)
  );

  // Sticky bits: [0] rx_overrun, [1] frame_err, [2] tx_drop, [3] parity_err.
  assign sticky_set = {par_err_set,
                       tx_push && tx_full && !tx_pop,
                       rx_done && !rx_line,
                       rx_done && rx_full && !rx_pop};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              sticky <= '0;
    else if (wr_acc && addr == REG_STATUS)  sticky <= (sticky & ~wdata[7:4]) | sticky_set;
    else                                    sticky <= sticky | sticky_set;
  end

  always_comb begin
    status = '0;
    status[ST_TX_FULL]    = tx_full;
    status[ST_TX_EMPTY]   = tx_empty;
    status[ST_RX_EMPTY]   = rx_empty;
    status[ST_RX_FULL]    = rx_full;
    status[ST_RX_OVERRUN] = sticky[0];
    status[ST_FRAME_ERR]  = sticky[1];
    status[ST_TX_DROP]    = sticky[2];
    status[ST_PARITY_ERR] = sticky[3];
    status[ST_RX_LEVEL_LSB +: 8] = 8'(rx_level);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= '0;
    else if (rd_acc) begin
      case (addr)
        REG_STATUS: rdata <= status;
        REG_RXDATA: rdata <= rx_empty ? 32'd0 : 32'(rx_dout);
        REG_DIV:    rdata <= {16'd0, div};
        REG_CTRL:   rdata <= {28'd0, ctrl};
        default:    rdata <= '0;
      endcase
    end
  end

  // One byte is prefetched into a holding register so STOP can chain straight into START.
  assign tx_pop      = !tx_empty && !hold_valid;
  assign tx_bit_done = tick && (tx_tick == LAST_TICK);
  assign tx_launch   = hold_valid && tick &&
                       ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_tick == LAST_TICK));
  assign tx_idle     = (tx_state == TX_IDLE) && !hold_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state   <= TX_IDLE;
      tx_tick    <= '0;
      tx_bit     <= '0;
      tx_shift   <= '0;
      tx_line    <= 1'b1;
      hold_valid <= 1'b0;
      hold_data  <= '0;
`ifdef UART_PARITY_EN
      tx_par     <= 1'b0;
`endif
    end else begin
      if (tx_pop) begin
        hold_valid <= 1'b1;
        hold_data  <= tx_dout;
      end
      if (tick && tx_state != TX_IDLE) tx_tick <= tx_tick + 4'd1;
      if (tx_launch) begin
        tx_state   <= TX_START;
        tx_shift   <= hold_data;
        hold_valid <= 1'b0;
        tx_line    <= 1'b0;
        tx_tick    <= '0;
`ifdef UART_PARITY_EN
        tx_par     <= (^hold_data) ^ 1'(PARITY_ODD);
`endif
      end else begin
        case (tx_state)
          TX_IDLE: tx_line <= 1'b1;
          TX_START: if (tx_bit_done) begin
            tx_state <= TX_DATA;
            tx_bit   <= '0;
            tx_line  <= tx_shift[0];
          end
          TX_DATA: if (tx_bit_done) begin
            if (tx_bit == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              tx_state <= TX_PARITY;
              tx_line  <= tx_par;
`else
              tx_state <= TX_STOP;
              tx_line  <= 1'b1;
`endif
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= tx_shift >> 1;
              tx_line  <= tx_shift[1];
            end
          end
`ifdef UART_PARITY_EN
          TX_PARITY: if (tx_bit_done) begin
            tx_state <= TX_STOP;
            tx_line  <= 1'b1;
          end
`endif
          TX_STOP: if (tx_bit_done) tx_state <= TX_IDLE;
          default: begin
            tx_state <= TX_IDLE;
            tx_line  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign txd = ctrl[CTRL_LOOPBACK] ? 1'b1 : tx_line;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], ctrl[CTRL_LOOPBACK] ? tx_line : rxd};
      rx_prev <= rx_line;
    end
  end

  assign rx_line   = rx_sync[1];
  assign rx_sample = tick && (rx_tick == LAST_TICK);
  assign rx_done   = (rx_state == RX_STOP) && rx_sample;

`ifdef UART_PARITY_EN
  assign par_err_set = (rx_state == RX_PARITY) && rx_sample &&
                       (rx_line != ((^rx_shift) ^ 1'(PARITY_ODD)));
`else
  assign par_err_set = 1'b0;
`endif

  // START re-checks the line at its 8th tick; later samples land 16 ticks apart, mid-bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_tick  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_line) begin
          rx_state <= RX_START;
          rx_tick  <= '0;
        end
        RX_START: if (tick) begin
          if (rx_tick == MID_TICK) begin
            rx_tick  <= '0;
            rx_bit   <= '0;
            rx_state <= rx_line ? RX_IDLE : RX_DATA;
          end else begin
            rx_tick <= rx_tick + 4'd1;
          end
        end
        RX_DATA: if (tick) begin
          rx_tick <= rx_tick + 4'd1;
          if (rx_sample) begin
            rx_shift <= {rx_line, rx_shift[DATA_BITS-1:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: if (tick) begin
          rx_tick <= rx_tick + 4'd1;
          if (rx_sample) rx_state <= RX_STOP;
        end
`endif
        RX_STOP: if (tick) begin
          rx_tick <= rx_tick + 4'd1;
          if (rx_sample) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign irq = (ctrl[CTRL_RX_IRQ_EN]  && !rx_empty) ||
               (ctrl[CTRL_TXE_IRQ_EN] && tx_empty && tx_idle) ||
               (ctrl[CTRL_ERR_IRQ_EN] && (|sticky));

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: register table, TX bit timing, loopback, overrun,
// tx_drop, RX glitch/framing and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_fifo;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        reset, valid, wstrb, rxd, txd, irq;
  logic [2:0]  addr;
  logic [31:0] wdata, rdata;
  int          vec_count = 0;
  int          miscompares = 0;
  bit          lb_mode = 1'b0;
  int          txd_low_in_lb = 0;

  uart_fifo dut (
    .clk(clk), .reset(reset), .valid(valid), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .rxd(rxd), .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (lb_mode && txd !== 1'b1) txd_low_in_lb++;

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] mask;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[17];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit wr, input logic [2:0] a, input logic [31:0] d, input int hold);
    @(negedge clk);
    valid = 1'b1; wstrb = wr; addr = a; wdata = d;
    repeat (hold) @(negedge clk);
    valid = 1'b0; wstrb = 1'b0;
  endtask

  task automatic readReg(input logic [2:0] a, output logic [31:0] d);
    applyStimulus(1'b0, a, 32'd0, 1);
    d = rdata;
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
    applyStimulus(1'b1, a, d, 1);
  endtask

  task automatic waitStatus(input logic [31:0] mask, input logic [31:0] value, input int budget, input string name);
    logic [31:0] st;
    int n = 0;
    readReg(REG_STATUS, st);
    while (((st & mask) != value) && n < budget) begin
      readReg(REG_STATUS, st);
      n++;
    end
    checkOutput(name, st & mask, value);
  endtask

  task automatic sendSerial(input logic [7:0] b, input logic stop_lvl);
    @(negedge clk);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (16) @(negedge clk);
    end
    rxd = stop_lvl;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] st;
    logic [7:0]  txb;
    logic        lvl, exp_lvl;
    int          run;

    reset = 1'b1; valid = 1'b0; wstrb = 1'b0; addr = '0; wdata = '0; rxd = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_txd", 32'(txd), 32'd1);
    checkOutput("reset_irq", 32'(irq), 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    reset = 1'b0;

    vecs[0]  = '{1'b0, REG_STATUS, 32'h0,        32'hFFFF_FFFF, 32'h0000_0006};
    vecs[1]  = '{1'b0, REG_DIV,    32'h0,        32'hFFFF_FFFF, 32'd325};
    vecs[2]  = '{1'b0, REG_CTRL,   32'h0,        32'hFFFF_FFFF, 32'h0};
    vecs[3]  = '{1'b0, REG_RXDATA, 32'h0,        32'hFFFF_FFFF, 32'h0};
    vecs[4]  = '{1'b0, REG_TXDATA, 32'h0,        32'hFFFF_FFFF, 32'h0};
    vecs[5]  = '{1'b0, 3'd5,       32'h0,        32'hFFFF_FFFF, 32'h0};
    vecs[6]  = '{1'b1, REG_DIV,    32'h0001_2345, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, REG_DIV,    32'h0,        32'hFFFF_FFFF, 32'h0000_2345};
    vecs[8]  = '{1'b1, REG_CTRL,   32'hFF,       32'h0,         32'h0};
    vecs[9]  = '{1'b0, REG_CTRL,   32'h0,        32'hFFFF_FFFF, 32'h0000_000F};
    vecs[10] = '{1'b1, 3'd6,       32'hFFFF_FFFF, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 3'd6,       32'h0,        32'hFFFF_FFFF, 32'h0};
    vecs[12] = '{1'b1, REG_CTRL,   32'h2,        32'h0,         32'h0};
    vecs[13] = '{1'b0, REG_CTRL,   32'h0,        32'hFFFF_FFFF, 32'h0000_0002};
    vecs[14] = '{1'b1, REG_DIV,    32'h3,        32'h0,         32'h0};
    vecs[15] = '{1'b0, REG_DIV,    32'h0,        32'hFFFF_FFFF, 32'h0000_0003};
    vecs[16] = '{1'b0, REG_STATUS, 32'h0,        32'hFFFF_FFFF, 32'h0000_0006};

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1);
      if (vecs[i].mask != 32'h0)
        checkOutput($sformatf("vec%0d", i), rdata & vecs[i].mask, vecs[i].exp);
    end
    checkOutput("irq_txe_idle", 32'(irq), 32'd1);

    // TX 0x55 at DIV=3: start + 8 alternating bits, each exactly 64 clocks
    txb = 8'h55;
    writeReg(REG_TXDATA, 32'h55);
    run = 0;
    while (txd === 1'b1 && run < 400) begin @(negedge clk); run++; end
    checkOutput("tx_start_seen", 32'(txd), 32'd0);
    checkOutput("irq_tx_busy", 32'(irq), 32'd0);
    for (int r = 0; r < 9; r++) begin
      lvl = txd;
      exp_lvl = (r == 0) ? 1'b0 : txb[r-1];
      run = 0;
      while (txd === lvl && run < 200) begin @(negedge clk); run++; end
      checkOutput($sformatf("tx_bit%0d_level", r), 32'(lvl), 32'(exp_lvl));
      checkOutput($sformatf("tx_bit%0d_len", r), 32'(run), 32'd64);
    end
    repeat (70) @(negedge clk);
    checkOutput("tx_idle_high", 32'(txd), 32'd1);
    readReg(REG_STATUS, st);
    checkOutput("tx_done_status", st, 32'h0000_0006);
    checkOutput("irq_tx_done", 32'(irq), 32'd1);

    // Loopback two bytes
    writeReg(REG_DIV, 32'h0);
    writeReg(REG_CTRL, 32'h8);
    lb_mode = 1'b1;
    writeReg(REG_TXDATA, 32'hA5);
    writeReg(REG_TXDATA, 32'h3C);
    waitStatus(32'h00FF_0000, 32'h0002_0000, 1000, "lb_level2");
    readReg(REG_RXDATA, st); checkOutput("lb_rx0", st, 32'h0000_00A5);
    readReg(REG_RXDATA, st); checkOutput("lb_rx1", st, 32'h0000_003C);
    readReg(REG_RXDATA, st); checkOutput("lb_rx_empty_read", st, 32'h0);
    readReg(REG_STATUS, st); checkOutput("lb_rx_empty_bit", st & 32'h4, 32'h4);

    // Valid held two cycles pops once
    writeReg(REG_TXDATA, 32'h11);
    writeReg(REG_TXDATA, 32'h22);
    waitStatus(32'h00FF_0000, 32'h0002_0000, 1000, "hold_level2");
    applyStimulus(1'b0, REG_RXDATA, 32'h0, 2);
    checkOutput("hold_rdata", rdata, 32'h0000_0011);
    readReg(REG_STATUS, st); checkOutput("hold_level1", st & 32'h00FF_0000, 32'h0001_0000);
    readReg(REG_RXDATA, st); checkOutput("hold_rx1", st, 32'h0000_0022);

    // FIFO_DEPTH+1 frames without reading -> overrun
    for (int i = 0; i < 17; i++) writeReg(REG_TXDATA, 32'h40 + 32'(i));
    waitStatus(32'h10, 32'h10, 4000, "ovr_set");
    readReg(REG_STATUS, st); checkOutput("ovr_status", st & 32'h00FF_0018, 32'h0010_0018);
    writeReg(REG_STATUS, 32'h10);
    readReg(REG_STATUS, st); checkOutput("ovr_cleared", st & 32'h18, 32'h08);
    readReg(REG_RXDATA, st); checkOutput("ovr_first_byte", st, 32'h0000_0040);
    checkOutput("lb_txd_held", 32'(txd_low_in_lb), 32'd0);
    writeReg(REG_CTRL, 32'h0);
    lb_mode = 1'b0;
    doReset();

    // TX drop: slow baud so nothing drains; 1 held + 16 queued + 1 dropped
    writeReg(REG_DIV, 32'hFFFF);
    for (int i = 0; i < 18; i++) writeReg(REG_TXDATA, 32'h80 + 32'(i));
    readReg(REG_STATUS, st); checkOutput("tx_drop_full", st & 32'h43, 32'h41);
    doReset();

    // RX glitch then framing error
    writeReg(REG_DIV, 32'h0);
    writeReg(REG_CTRL, 32'h4);
    @(negedge clk); rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (60) @(negedge clk);
    readReg(REG_STATUS, st); checkOutput("glitch_status", st & 32'h00FF_0024, 32'h0000_0004);
    checkOutput("glitch_irq", 32'(irq), 32'd0);
    sendSerial(8'hC3, 1'b0);
    repeat (20) @(negedge clk);
    readReg(REG_STATUS, st); checkOutput("ferr_status", st & 32'h00FF_0024, 32'h0001_0020);
    checkOutput("ferr_irq", 32'(irq), 32'd1);
    readReg(REG_RXDATA, st); checkOutput("ferr_byte", st, 32'h0000_00C3);
    writeReg(REG_STATUS, 32'h20);
    checkOutput("ferr_irq_clear", 32'(irq), 32'd0);
    sendSerial(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    readReg(REG_STATUS, st); checkOutput("good_frame_status", st & 32'h00FF_0024, 32'h0001_0000);
    readReg(REG_RXDATA, st); checkOutput("good_frame_byte", st, 32'h0000_005A);
    writeReg(REG_CTRL, 32'h0);

    // Reset mid-TX-frame
    writeReg(REG_TXDATA, 32'h00);
    writeReg(REG_TXDATA, 32'h00);
    writeReg(REG_TXDATA, 32'h00);
    run = 0;
    while (txd === 1'b1 && run < 200) begin @(negedge clk); run++; end
    repeat (20) @(negedge clk);
    checkOutput("rst_pre_low", 32'(txd), 32'd0);
    #2 reset = 1'b1;
    #1 checkOutput("rst_txd_async", 32'(txd), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    readReg(REG_STATUS, st); checkOutput("rst_tx_empty", st & 32'h06, 32'h06);
    repeat (40) @(negedge clk);
    checkOutput("rst_txd_idle", 32'(txd), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
